// File: rtl/lsu_pkg.sv
// Shared types and helpers for the byte-enable load-store unit.
package lsu_pkg;

  // Access size/sign selector as presented on req_rwsel.
  typedef enum logic [2:0] {
    RW_B  = 3'b000,
    RW_H  = 3'b001,
    RW_W  = 3'b010,
    RW_BU = 3'b100,
    RW_HU = 3'b101
  } rwsel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RG_DMEM = 2'd0,
    RG_OUT  = 2'd1,
    RG_IN   = 2'd2,
    RG_NONE = 2'd3
  } region_e;

  // addr[11:8] values selecting the I/O regions; dmem is any addr[11]=0.
  localparam logic [3:0] REGION_OUT = 4'b1000;
  localparam logic [3:0] REGION_IN  = 4'b1001;

  // Byte lanes touched by a store of the given size at the given offset.
  function automatic logic [3:0] byte_en(input logic [2:0] rwsel, input logic [1:0] off);
    logic [3:0] be;
    case (rwsel[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate store data across lanes so the byte enables pick the right copy.
  function automatic logic [31:0] store_data(input logic [2:0] rwsel, input logic [31:0] wdata);
    logic [31:0] d;
    case (rwsel[1:0])
      2'b00:   d = {4{wdata[7:0]}};
      2'b01:   d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  // Align the addressed lane down to bit 0 and sign/zero extend.
  function automatic logic [31:0] load_format(input logic [2:0] rwsel, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] d;
    sh = word >> {off, 3'b000};
    case (rwsel)
      RW_B:    d = {{24{sh[7]}}, sh[7:0]};
      RW_BU:   d = {24'h0, sh[7:0]};
      RW_H:    d = {{16{sh[15]}}, sh[15:0]};
      RW_HU:   d = {16'h0, sh[15:0]};
      default: d = sh;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dmem_be.sv
// Data memory: synchronous read, per-byte write enables, contents not reset.
module dmem_be #(
  parameter int unsigned DMEM_WORDS = 512,
  parameter int unsigned AW         = 9
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DMEM_WORDS];
  logic [31:0] rdata_q;

  // Byte-lane writes and registered read; the unit never reads and writes in the same cycle.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lsu_be.sv
// Handshaked load-store unit: dmem, output registers and synchronised input ports.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a request; stores/errors resolve at the accept edge
// ST_LOAD | dmem read in flight; format selected word into resp_rdata
// ST_RESP | resp_valid pulse for the accepted request
module lsu_be
  import lsu_pkg::*;
#(
  parameter int unsigned DMEM_WORDS = 512,
  parameter int unsigned NUM_OUT    = 11,
  parameter int unsigned NUM_IN     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [11:0]             req_addr,
  input  logic [31:0]             req_wdata,
  input  logic [2:0]              req_rwsel,
  output logic                    resp_valid,
  output logic [31:0]             resp_rdata,
  output logic                    resp_err,
  input  logic [NUM_IN*32-1:0]    in_data,
  output logic [NUM_OUT*32-1:0]   out_data
);

  localparam int unsigned DMEM_AW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

  state_e              state_q, state_d;
  logic [2:0]          ld_rwsel_q;
  logic [1:0]          ld_off_q;
  region_e             ld_region_q;
  logic [5:0]          ld_idx_q;
  logic [31:0]         resp_rdata_q;
  logic                resp_err_q;
  logic [31:0]         out_q [NUM_OUT];
  logic [NUM_IN*32-1:0] sync1_q, sync2_q;

  logic [8:0]  dmem_idx;
  logic [5:0]  io_idx;
  logic [1:0]  off;
  region_e     region;
  logic        region_ok, size_ok, req_err;
  logic        accept, st_ok, dmem_we, dmem_re, out_we;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [31:0] dmem_rdata, out_rd, in_rd, ld_word;

  assign dmem_idx = req_addr[10:2];
  assign io_idx   = req_addr[7:2];
  assign off      = req_addr[1:0];

  // Region and index range decode.
  always_comb begin
    region    = RG_NONE;
    region_ok = 1'b0;
    if (!req_addr[11]) begin
      region    = RG_DMEM;
      region_ok = 32'(dmem_idx) < DMEM_WORDS;
    end else if (req_addr[11:8] == REGION_OUT) begin
      region    = RG_OUT;
      region_ok = 32'(io_idx) < NUM_OUT;
    end else if (req_addr[11:8] == REGION_IN) begin
      region    = RG_IN;
      region_ok = (32'(io_idx) < NUM_IN) && !req_we;
    end
  end

  // Size/alignment legality; unsigned selectors exist only for loads.
  always_comb begin
    size_ok = 1'b0;
    case (req_rwsel)
      RW_B:    size_ok = 1'b1;
      RW_H:    size_ok = !off[0];
      RW_W:    size_ok = (off == 2'b00);
      RW_BU:   size_ok = !req_we;
      RW_HU:   size_ok = !req_we && !off[0];
      default: size_ok = 1'b0;
    endcase
  end

  assign req_err = !(region_ok && size_ok);
  assign accept  = req_valid && req_ready;
  assign st_ok   = accept && req_we && !req_err;
  assign dmem_we = st_ok && (region == RG_DMEM);
  assign out_we  = st_ok && (region == RG_OUT);
  assign dmem_re = accept && !req_we && !req_err && (region == RG_DMEM);
  assign be      = byte_en(req_rwsel, off);
  assign wd      = store_data(req_rwsel, req_wdata);

  dmem_be #(
    .DMEM_WORDS(DMEM_WORDS),
    .AW        (DMEM_AW)
  ) u_dmem (
    .clk_i  (clk),
    .we_i   (dmem_we),
    .be_i   (be),
    .re_i   (dmem_re),
    .addr_i (dmem_idx[DMEM_AW-1:0]),
    .wdata_i(wd),
    .rdata_o(dmem_rdata)
  );

  // Output register file with byte-lane writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_OUT; i++) out_q[i] <= '0;
    end else if (out_we) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (io_idx == 6'(i)) begin
          for (int b = 0; b < 4; b++) begin
            if (be[b]) out_q[i][8*b +: 8] <= wd[8*b +: 8];
          end
        end
      end
    end
  end

  genvar g;
  for (g = 0; g < NUM_OUT; g++) begin : g_out
    assign out_data[32*g +: 32] = out_q[g];
  end

  // Two-flop synchroniser on every input bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_data;
      sync2_q <= sync1_q;
    end
  end

  // Select the word for the load being completed.
  always_comb begin
    out_rd = '0;
    in_rd  = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (ld_idx_q == 6'(i)) out_rd = out_q[i];
    end
    for (int i = 0; i < NUM_IN; i++) begin
      if (ld_idx_q == 6'(i)) in_rd = sync2_q[32*i +: 32];
    end
    case (ld_region_q)
      RG_DMEM: ld_word = dmem_rdata;
      RG_OUT:  ld_word = out_rd;
      RG_IN:   ld_word = in_rd;
      default: ld_word = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic: only clean loads need the extra read cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = (req_err || req_we) ? ST_RESP : ST_LOAD;
      ST_LOAD: state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture and response registers; errors clear the read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_rwsel_q   <= '0;
      ld_off_q     <= '0;
      ld_region_q  <= RG_NONE;
      ld_idx_q     <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        ld_rwsel_q  <= req_rwsel;
        ld_off_q    <= off;
        ld_region_q <= region;
        ld_idx_q    <= io_idx;
        resp_err_q  <= req_err;
        if (req_err) resp_rdata_q <= '0;
      end else if (state_q == ST_LOAD) begin
        resp_rdata_q <= load_format(ld_rwsel_q, ld_off_q, ld_word);
      end
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_err   = resp_valid && resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_lsu_be.sv
// Directed bench for lsu_be with a response scoreboard.
module tb_lsu_be;

  localparam int DW = 256;
  localparam int NO = 11;
  localparam int NI = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_we = 1'b0;
  logic [11:0]     req_addr = '0;
  logic [31:0]     req_wdata = '0;
  logic [2:0]      req_rwsel = '0;
  logic            resp_valid;
  logic [31:0]     resp_rdata;
  logic            resp_err;
  logic [NI*32-1:0] in_data = '0;
  logic [NO*32-1:0] out_data;

  lsu_be #(.DMEM_WORDS(DW), .NUM_OUT(NO), .NUM_IN(NI)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_rwsel (req_rwsel),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .in_data   (in_data),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk_rd;
    int          at;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   req_id   = 0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop and compare on every response pulse.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      checks++;
      assert (sb.size() != 0)
      else begin
        failures++;
        $error("FAIL unexpected_resp observed=resp_valid expected=none cyc=%0d", cyc);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check32($sformatf("req%0d_err", e.id), {31'h0, resp_err}, {31'h0, e.err});
        check32($sformatf("req%0d_latency", e.id), cyc, e.at);
        if (e.chk_rd) check32($sformatf("req%0d_rdata", e.id), resp_rdata, e.rdata);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check32("req_ready_wait", {31'h0, req_ready}, 32'h1);
  endtask

  task automatic drive_req(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                           input logic [2:0] sel, input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_rwsel = sel;
    e.err    = exp_err;
    e.rdata  = exp_err ? 32'h0 : exp_rd;
    e.chk_rd = exp_err || !we;
    e.at     = cyc + ((exp_err || we) ? 1 : 2);
    e.id     = req_id++;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = 12'($urandom);
    req_wdata = $urandom;
    req_rwsel = 3'($urandom);
  endtask

  task automatic wait_resp();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check32("resp_timeout_pending", sb.size(), 0);
    sb.delete();
  endtask

  task automatic op(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                    input logic [2:0] sel, input logic [31:0] exp_rd, input logic exp_err);
    wait_ready();
    drive_req(we, addr, wdata, sel, exp_rd, exp_err);
    wait_resp();
  endtask

  initial begin
    in_data[63:32] = 32'h12345678;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check32("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check32("rst_resp_err", {31'h0, resp_err}, 32'h0);
    check32("rst_resp_rdata", resp_rdata, 32'h0);
    check32("rst_out_w0", out_data[31:0], 32'h0);
    check32("rst_out_w10", out_data[351:320], 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check32("rst_req_ready", {31'h0, req_ready}, 32'h1);

    // Basic word/byte/half access in dmem.
    op(1, 12'h010, 32'h11223344, 3'b010, 32'h0, 0);
    op(0, 12'h011, 32'h0, 3'b000, 32'h00000033, 0);
    op(0, 12'h013, 32'h0, 3'b000, 32'h00000011, 0);
    op(0, 12'h012, 32'h0, 3'b001, 32'h00001122, 0);
    op(0, 12'h010, 32'h0, 3'b010, 32'h11223344, 0);

    // Byte store merges; sign vs zero extension.
    op(1, 12'h012, 32'h000000AB, 3'b000, 32'h0, 0);
    op(0, 12'h010, 32'h0, 3'b010, 32'h11AB3344, 0);
    op(0, 12'h012, 32'h0, 3'b000, 32'hFFFFFFAB, 0);
    op(0, 12'h012, 32'h0, 3'b100, 32'h000000AB, 0);
    op(0, 12'h012, 32'h0, 3'b101, 32'h000011AB, 0);
    op(1, 12'h010, 32'hFFFF8001, 3'b001, 32'h0, 0);
    op(0, 12'h010, 32'h0, 3'b001, 32'hFFFF8001, 0);
    op(0, 12'h010, 32'h0, 3'b010, 32'h11AB8001, 0);

    // Misalignment errors leave state untouched.
    op(1, 12'h801, 32'h0000BEEF, 3'b001, 32'h0, 1);
    check32("err_out_w0", out_data[31:0], 32'h0);
    op(0, 12'h003, 32'h0, 3'b010, 32'h0, 1);
    op(0, 12'h011, 32'h0, 3'b101, 32'h0, 1);
    op(0, 12'h010, 32'h0, 3'b011, 32'h0, 1);
    op(1, 12'h010, 32'h0, 3'b100, 32'h0, 1);
    op(0, 12'h010, 32'h0, 3'b010, 32'h11AB8001, 0);

    // Output registers.
    wait_ready();
    drive_req(1, 12'h808, 32'h0000007F, 3'b010, 32'h0, 0);
    check32("out_w2_at_t1", out_data[95:64], 32'h0000007F);
    wait_resp();
    op(0, 12'h808, 32'h0, 3'b010, 32'h0000007F, 0);
    op(0, 12'h808, 32'h0, 3'b100, 32'h0000007F, 0);
    op(1, 12'h82B, 32'h000000C3, 3'b000, 32'h0, 0);
    check32("out_w10_byte3", out_data[351:320], 32'hC3000000);
    op(1, 12'h82C, 32'h1, 3'b010, 32'h0, 1);
    op(0, 12'h82C, 32'h0, 3'b010, 32'h0, 1);

    // Input ports and synchroniser delay.
    op(1, 12'h900, 32'h1, 3'b010, 32'h0, 1);
    wait_ready();
    in_data[31:0] = 32'h000000A5;
    drive_req(0, 12'h900, 32'h0, 3'b010, 32'h0, 0);
    wait_resp();
    op(0, 12'h900, 32'h0, 3'b010, 32'h000000A5, 0);
    op(0, 12'h904, 32'h0, 3'b010, 32'h12345678, 0);
    op(0, 12'h906, 32'h0, 3'b001, 32'h00001234, 0);
    op(0, 12'h908, 32'h0, 3'b010, 32'h0, 1);

    // Unmapped and dmem range boundary.
    op(0, 12'hA00, 32'h0, 3'b010, 32'h0, 1);
    op(0, 12'h400, 32'h0, 3'b010, 32'h0, 1);
    op(1, 12'h3FC, 32'hCAFEF00D, 3'b010, 32'h0, 0);
    op(0, 12'h3FC, 32'h0, 3'b010, 32'hCAFEF00D, 0);

    // Reset while a load is in flight.
    wait_ready();
    drive_req(0, 12'h010, 32'h0, 3'b010, 32'h11AB8001, 0);
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check32("midrst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check32("midrst_out_w2", out_data[95:64], 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check32("postrst_req_ready", {31'h0, req_ready}, 32'h1);
    check32("postrst_rdata", resp_rdata, 32'h0);
    check32("postrst_out_w10", out_data[351:320], 32'h0);
    repeat (4) @(negedge clk);
    op(0, 12'h010, 32'h0, 3'b010, 32'h11AB8001, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
